// File: rtl/fp_add_sched.sv
// fp_add_sched: round-robin scheduler sharing one FP add datapath between two
// requesters, with a fixed multicycle settle window and a tagged response.
//
// Ports:
//   i_clk, i_rst_n              clock, async active-low reset
//   i_req0_* / o_req0_ready     requester 0 valid/ready and operands a/b
//   i_req1_* / o_req1_ready     requester 1 valid/ready and operands a/b
//   o_dp_a, o_dp_b, o_dp_en     registered operands and live flag to the adder
//   i_dp_n                      packed result word from the adder
//   o_rsp_valid, i_rsp_ready    response handshake
//   o_rsp_data, o_rsp_id        captured result and issuing requester id
//   o_busy                      high whenever the FSM is not idle
module fp_add_sched #(
    parameter int EXEC_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req0_valid,
    output logic        o_req0_ready,
    input  logic [31:0] i_req0_a,
    input  logic [31:0] i_req0_b,
    input  logic        i_req1_valid,
    output logic        o_req1_ready,
    input  logic [31:0] i_req1_a,
    input  logic [31:0] i_req1_b,
    output logic [31:0] o_dp_a,
    output logic [31:0] o_dp_b,
    output logic        o_dp_en,
    input  logic [31:0] i_dp_n,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_id,
    output logic        o_busy
);

    if (EXEC_CYCLES < 1 || EXEC_CYCLES > 15) begin : g_bad_exec
        $error("fp_add_sched: EXEC_CYCLES must be in 1..15");
    end

    if ((64'd1 << CNT_W) <= 64'(EXEC_CYCLES)) begin : g_bad_cnt
        $error("fp_add_sched: CNT_W too narrow for EXEC_CYCLES");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t             r_state;
    logic               r_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_id;
    logic [31:0]        r_dp_a;
    logic [31:0]        r_dp_b;
    logic               r_dp_en;
    logic               r_rsp_valid;
    logic [31:0]        r_rsp_data;
    logic               r_rsp_id;

    logic               w_idle;
    logic               w_gnt0;
    logic               w_gnt1;

    // A lone valid requester always wins; on contention the pointer decides.
    assign w_idle = (r_state == S_IDLE);
    assign w_gnt0 = i_req0_valid & (~i_req1_valid | ~r_ptr);
    assign w_gnt1 = i_req1_valid & (~i_req0_valid |  r_ptr);

    assign o_req0_ready = w_idle & w_gnt0;
    assign o_req1_ready = w_idle & w_gnt1;

    assign o_dp_a      = r_dp_a;
    assign o_dp_b      = r_dp_b;
    assign o_dp_en     = r_dp_en;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_id    = r_rsp_id;
    assign o_busy      = ~w_idle;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= 1'b0;
            r_cnt       <= '0;
            r_id        <= 1'b0;
            r_dp_a      <= '0;
            r_dp_b      <= '0;
            r_dp_en     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_gnt0 | w_gnt1) begin
                        r_dp_a  <= w_gnt1 ? i_req1_a : i_req0_a;
                        r_dp_b  <= w_gnt1 ? i_req1_b : i_req0_b;
                        r_id    <= w_gnt1;
                        // Favour the loser next time.
                        r_ptr   <= ~w_gnt1;
                        r_cnt   <= CNT_W'(EXEC_CYCLES - 1);
                        r_dp_en <= 1'b1;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        // Operands have settled for EXEC_CYCLES edges.
                        r_rsp_data  <= i_dp_n;
                        r_rsp_id    <= r_id;
                        r_rsp_valid <= 1'b1;
                        r_dp_en     <= 1'b0;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
